// File: rtl/coef_stream_pkg.sv
// coef_pkg: shared types and default sizing for the coefficient streamer.
package coef_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/coef_stream_if.sv
// coef_stream_if: valid/ready stream carrying one coefficient word per transfer.
interface coef_stream_if
  import coef_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/coef_stream_table.sv
// coef_table: coefficient register array, synchronous write, asynchronous read.
// Storage is rounded up to a power of two so every address is in range;
// entries at or beyond DEPTH are never read by the streamer.
module coef_table
  import coef_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int SLOTS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [SLOTS];

  // Table contents are deliberately not reset; they are valid once written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/coef_stream.sv
// coef_stream: streams the first min(len, DEPTH) table words on a valid/ready
// interface and accumulates their signed sum.
// Optional macro COEF_STREAM_TRACE_EN adds a simulation-only transfer/done trace.
module coef_stream
  import coef_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SUM_W  = DATA_W + ADDR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    done,
  output logic signed [SUM_W-1:0] sum,
  coef_stream_if.master           m
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t                   state;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        idx_next;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W:0]          eff_len;
  logic [ADDR_W:0]          last_idx;
  logic [DATA_W-1:0]        rd_data;
  logic [DATA_W-1:0]        next_word;
  logic signed [SUM_W-1:0]  word_ext;
  logic                     xfer;

  assign eff_len  = (len > DEPTH_L) ? DEPTH_L : len;
  assign idx_next = idx + ADDR_W'(1);
  // The word to load next is table[0] on a start, otherwise the one after idx
  assign rd_addr  = (state == IDLE) ? '0 : idx_next;
  // Forward a same-cycle write so the newly presented word is never stale
  assign next_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_data;
  assign word_ext  = {{(SUM_W-DATA_W){m.m_data[DATA_W-1]}}, m.m_data};
  assign xfer      = m.m_valid && m.m_ready;

  coef_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stream FSM with registered handshake, status and running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      last_idx  <= '0;
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      m.m_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sum      <= '0;
            idx      <= '0;
            last_idx <= eff_len - ONE_L;
            busy     <= 1'b1;
            if (eff_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              m.m_valid <= 1'b1;
              m.m_data  <= next_word;
              m.m_last  <= (eff_len == ONE_L);
            end
          end
        end
        RUN: begin
          if (xfer) begin
            sum <= sum + word_ext;
            if (m.m_last) begin
              state     <= DONE;
              done      <= 1'b1;
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
            end else begin
              idx      <= idx_next;
              m.m_data <= next_word;
              m.m_last <= ({1'b0, idx_next} == last_idx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          m.m_valid <= 1'b0;
          m.m_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COEF_STREAM_TRACE_EN
  // Simulation-only trace of each transfer and of the final sum
  always @(posedge clk) begin
    if (rst_n && xfer) $display("[coef_stream] idx=%0d data=%b", idx, m.m_data);
    if (rst_n && state == DONE) $display("[coef_stream] done sum=%0d", sum);
  end
`else
  // No trace logic in the default build
`endif

endmodule

// File: tb/tb_coef_stream.sv
// tb_coef_stream: directed self-checking bench for coef_stream.
module tb_coef_stream;
  import coef_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SUM_W  = DATA_W + ADDR_W + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wr_en = 1'b0;
  logic [ADDR_W-1:0]       wr_addr = '0;
  logic [DATA_W-1:0]       wr_data = '0;
  logic                    start = 1'b0;
  logic [ADDR_W:0]         len = '0;
  logic                    busy;
  logic                    done;
  logic signed [SUM_W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  // Bench copy of the table contents: fc bias words then small fillers
  int vals [16] = '{-48, 1081, -146, -256, -109, 976, 31, 466, -905, 33,
                    1, 2, 3, 4, 5, 6};
  logic [DATA_W-1:0] coef [16];

  coef_stream_if #(.DATA_W(DATA_W)) bus ();

  coef_stream #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .m       (bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic write_word(input int addr, input logic [DATA_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Launch one stream and follow it to completion against the bench table
  task automatic apply_stimulus(input string tag, input int n_len, input bit toggle,
                                input bit hold_start, input int exp_n,
                                input int exp_sum, input int exp_done_cycle);
    int cnt;
    int valid_cycles;
    int done_cycle;
    bit finished;
    cnt = 0;
    valid_cycles = 0;
    done_cycle = -1;
    finished = 1'b0;
    start = 1'b1;
    len = (ADDR_W+1)'(n_len);
    bus.m_ready = 1'b1;
    tick();
    if (hold_start) len = (ADDR_W+1)'(1);
    else start = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      bus.m_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (bus.m_valid) begin
        valid_cycles++;
        if (cnt < exp_n) begin
          check_output({tag, "_data"}, 32'(bus.m_data), 32'(coef[cnt]));
          check_output({tag, "_last"}, 32'(bus.m_last), 32'(cnt == exp_n - 1));
        end else begin
          check_output({tag, "_extra_valid"}, 32'(bus.m_valid), 32'(0));
        end
        if (bus.m_ready) cnt++;
      end
      if (done) begin
        finished = 1'b1;
        done_cycle = c;
        start = 1'b0;
        check_output({tag, "_valid_at_done"}, 32'(bus.m_valid), 32'(0));
        check_output({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      end
      tick();
    end
    check_output({tag, "_done_seen"}, 32'(finished), 32'(1));
    check_output({tag, "_done_cycle"}, 32'(done_cycle), 32'(exp_done_cycle));
    check_output({tag, "_xfers"}, 32'(cnt), 32'(exp_n));
    check_output({tag, "_valid_cycles"}, 32'(valid_cycles), 32'(toggle ? 2 * exp_n - 1 : exp_n));
    check_output({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    check_output({tag, "_idle"}, 32'(busy), 32'(0));
    check_output({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    bus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) coef[i] = vals[i][DATA_W-1:0];

    // Reset state
    tick();
    tick();
    check_output("rst_valid", 32'(bus.m_valid), 32'(0));
    check_output("rst_last", 32'(bus.m_last), 32'(0));
    check_output("rst_data", 32'(bus.m_data), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_done", 32'(done), 32'(0));
    check_output("rst_sum", 32'(sum), 32'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) write_word(i, coef[i]);

    // Full-rate stream of ten words
    apply_stimulus("len10", 10, 1'b0, 1'b0, 10, 1123, 10);

    // Back-pressure every other cycle, with start held high and ignored while busy
    apply_stimulus("toggle", 10, 1'b1, 1'b1, 10, 1123, 19);

    // Zero length goes straight to done
    apply_stimulus("len0", 0, 1'b0, 1'b0, 0, 0, 0);

    // Length beyond DEPTH is clamped to the whole table
    apply_stimulus("len20", 20, 1'b0, 1'b0, 16, 1144, 16);

    // Writes during a stall: current word holds, a later word is picked up
    start = 1'b1;
    len = (ADDR_W+1)'(4);
    bus.m_ready = 1'b0;
    tick();
    start = 1'b0;
    check_output("wr_first_data", 32'(bus.m_data), 32'(coef[0]));
    wr_en = 1'b1;
    wr_addr = ADDR_W'(0);
    wr_data = 16'd7;
    tick();
    wr_addr = ADDR_W'(2);
    wr_data = 16'd555;
    tick();
    wr_en = 1'b0;
    check_output("wr_hold_data", 32'(bus.m_data), 32'(coef[0]));
    check_output("wr_hold_valid", 32'(bus.m_valid), 32'(1));
    bus.m_ready = 1'b1;
    tick();
    check_output("wr_word1", 32'(bus.m_data), 32'(coef[1]));
    tick();
    check_output("wr_word2", 32'(bus.m_data), 32'(555));
    tick();
    check_output("wr_word3", 32'(bus.m_data), 32'(coef[3]));
    check_output("wr_word3_last", 32'(bus.m_last), 32'(1));
    tick();
    check_output("wr_done", 32'(done), 32'(1));
    check_output("wr_sum", 32'(sum), 32'(1332));
    tick();
    write_word(0, coef[0]);
    write_word(2, coef[2]);

    // Asynchronous reset while the fourth word is presented
    start = 1'b1;
    len = (ADDR_W+1)'(10);
    bus.m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_output("abort_at_word3", 32'(bus.m_data), 32'(coef[3]));
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", 32'(bus.m_valid), 32'(0));
    check_output("abort_last", 32'(bus.m_last), 32'(0));
    check_output("abort_data", 32'(bus.m_data), 32'(0));
    check_output("abort_busy", 32'(busy), 32'(0));
    check_output("abort_done", 32'(done), 32'(0));
    check_output("abort_sum", 32'(sum), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("abort_no_done", 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    tick();
    apply_stimulus("restart", 10, 1'b0, 1'b0, 10, 1123, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coef_stream.md
COEF_STREAM -- requirements
Module: coef_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16: coefficient word width, two's complement.
REQ-002 SHALL have parameter DEPTH, default 16: number of table entries, 2..1024.
REQ-003 SHALL have local parameter ADDR_W = $clog2(DEPTH), and local parameter SUM_W = DATA_W+ADDR_W+1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1 bit: table write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W bits: table write address.
REQ-008 SHALL have port wr_data, input, DATA_W bits: table write data.
REQ-009 SHALL have port start, input, 1 bit: begin a stream; sampled only in IDLE.
REQ-010 SHALL have port len, input, ADDR_W+1 bits: word count; sampled with start.
REQ-011 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port m_data, output, DATA_W bits: coefficient word.
REQ-014 SHALL have port m_last, output, 1 bit: marks the final word.
REQ-015 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle end pulse.
REQ-017 SHALL have port sum, output, SUM_W bits: signed sum of the words streamed.

Function
REQ-018 FSM SHALL have states IDLE, RUN and DONE; only IDLE accepts start.
REQ-019 In IDLE with start=1, the effective length SHALL be min(len, DEPTH); a length of 0 goes to DONE, anything else goes to RUN.
REQ-020 On start, sum and the read index SHALL clear to 0.
REQ-021 m_valid SHALL rise the cycle after start, with m_data = table[0] (latency 1).
REQ-022 A transfer SHALL occur when m_valid && m_ready; on a transfer, sum += sign-extended m_data and the index increments.
REQ-023 While m_valid && !m_ready, m_data and m_last SHALL hold stable.
REQ-024 m_last SHALL be high iff index == effective length-1.
REQ-025 A transfer with m_last SHALL move RUN to DONE; m_valid drops the next cycle.
REQ-026 DONE SHALL last exactly one cycle, with done=1, then return to IDLE; sum holds until the next start.
REQ-027 A len=0 start SHALL produce done one cycle later, with no m_valid and sum=0.
REQ-028 start while busy SHALL be ignored.
REQ-029 Table writes SHALL be accepted in any state.
REQ-030 A write to the word currently presented SHALL not alter m_data; a write to a later index SHALL be seen when that word is presented.
REQ-031 sum SHALL never overflow, since SUM_W covers DEPTH words of full-scale magnitude.

Reset
REQ-032 rst_n low SHALL asynchronously force: FSM to IDLE, index 0, m_valid 0, m_last 0, m_data 0, busy 0, done 0, sum 0.
REQ-033 Reset SHALL not clear table contents; they are undefined until written.
REQ-034 Reset mid-RUN SHALL abort the stream, with no done pulse.
REQ-035 After reset release, the first start SHALL behave per REQ-019.

Configuration
REQ-036 With COEF_STREAM_TRACE_EN defined, every transfer SHALL $display the index and m_data in binary (%b), and done SHALL $display the sum in decimal; this is simulation-only.
REQ-037 Without COEF_STREAM_TRACE_EN defined, no system tasks SHALL be present and the logic is identical.

Structure
REQ-038 The package coef_pkg SHALL hold the FSM state enum typedef and the default DATA_W/DEPTH constants.
REQ-039 There SHALL be one sub-module, coef_table: a register array with a synchronous write port and an asynchronous read port, parametrised by DATA_W/DEPTH.

Verification
REQ-040 Load fc bias words -48, 1081, -146, -256, -109, 976, 31, 466, -905, 33; start with len=10 and m_ready=1 -> 10 consecutive transfers, m_last on 33, done, sum=1123.
REQ-041 Same load; toggle m_ready 1/0 every cycle -> identical data order, m_data stable during stalls, sum=1123.
REQ-042 len=0 -> done one cycle after start, m_valid never high, sum=0.
REQ-043 len=20 with DEPTH=16 -> exactly 16 transfers, m_last on index 15.
REQ-044 Assert rst_n=0 at the 4th transfer -> all outputs 0 at once, no done; a restart with len=10 gives sum=1123.
REQ-045 With COEF_STREAM_TRACE_EN defined, the first trace line SHALL show 1111111111010000 (-48).
